// File: rtl/pipe_interlock_ctrl.sv
// pipe_interlock_ctrl -- in-order pipeline interlock controller.
//
// Keeps a 3-entry scoreboard that shadows the EX, MEM and WB stages and
// decides each cycle, combinationally, whether decode may issue.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_valid                    decode holds a real instruction
//   id_rs1/id_rs2               decode source indices
//   id_use_rs1/id_use_rs2       source is actually read
//   id_rd/id_wr                 decode destination and write enable
//   ex_redirect                 taken branch/jump resolved in EX
//   mem_busy                    data memory not ready, whole pipe holds
//   clr_stats                   synchronous clear of stall_cycles
//   stall_if                    hold PC and IF/ID
//   flush_id                    clear IF/ID
//   bubble_ex                   load a NOP into ID/EX
//   freeze                      hold ID/EX, EX/MEM, MEM/WB
//   state                       registered controller state
//   stall_cycles                saturating count of non-RUN cycles

// Per-entry RAW match against the decode sources.
module pipe_interlock_hit #(
  parameter int RW = 5
) (
  input  logic          i_v,
  input  logic          i_wr,
  input  logic [RW-1:0] i_rd,
  input  logic [RW-1:0] i_rs1,
  input  logic [RW-1:0] i_rs2,
  input  logic          i_use1,
  input  logic          i_use2,
  output logic          o_hit
);
  // x0 is hardwired to zero, so a write to it never produces a value.
  assign o_hit = i_v & i_wr & (i_rd != '0) &
                 ((i_use1 & (i_rs1 == i_rd)) | (i_use2 & (i_rs2 == i_rd)));
endmodule

module pipe_interlock_ctrl #(
  parameter int XLEN_REGS = 32,
  parameter int STATW     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid,
  input  logic [$clog2(XLEN_REGS)-1:0] id_rs1,
  input  logic [$clog2(XLEN_REGS)-1:0] id_rs2,
  input  logic                         id_use_rs1,
  input  logic                         id_use_rs2,
  input  logic [$clog2(XLEN_REGS)-1:0] id_rd,
  input  logic                         id_wr,
  input  logic                         ex_redirect,
  input  logic                         mem_busy,
  input  logic                         clr_stats,
  output logic                         stall_if,
  output logic                         flush_id,
  output logic                         bubble_ex,
  output logic                         freeze,
  output logic [1:0]                   state,
  output logic [STATW-1:0]             stall_cycles
);
  localparam int RW = $clog2(XLEN_REGS);
  localparam int EX = 0, MEM = 1, WB = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    RAW   = 2'd1,
    MEMW  = 2'd2,
    FLUSH = 2'd3
  } st_t;

  typedef struct packed {
    logic          v;
    logic [RW-1:0] rd;
    logic          wr;
  } sb_ent_t;

  sb_ent_t [2:0]    r_sb;
  st_t              r_state;
  logic [STATW-1:0] r_sc;

  logic [1:0] w_hit;
  logic       w_raw;
  st_t        w_nxt;
  sb_ent_t    w_new;
  logic       w_stall_if, w_flush_id, w_bubble_ex, w_freeze;

  // Only EX and MEM can stall decode; WB writes the register file in the
  // first half-cycle so decode reads the fresh value.
  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_hit
      pipe_interlock_hit #(.RW(RW)) u_hit (
        .i_v    (r_sb[g].v),
        .i_wr   (r_sb[g].wr),
        .i_rd   (r_sb[g].rd),
        .i_rs1  (id_rs1),
        .i_rs2  (id_rs2),
        .i_use1 (id_use_rs1),
        .i_use2 (id_use_rs2),
        .o_hit  (w_hit[g])
      );
    end
  endgenerate

  assign w_raw = id_valid & (|w_hit);

  // The WB shadow is tracked for completeness but never feeds a decision.
  logic w_unused_wb;
  assign w_unused_wb = ^r_sb[WB];

  always_comb begin
    w_nxt       = RUN;
    w_stall_if  = 1'b0;
    w_flush_id  = 1'b0;
    w_bubble_ex = 1'b0;
    w_freeze    = 1'b0;
    w_new       = '{v: id_valid, rd: id_rd, wr: id_wr};
    if (mem_busy) begin
      w_nxt      = MEMW;
      w_freeze   = 1'b1;
      w_stall_if = 1'b1;
    end else if (ex_redirect) begin
      w_nxt       = FLUSH;
      w_flush_id  = 1'b1;
      w_bubble_ex = 1'b1;
      w_new       = '0;
    end else if (w_raw) begin
      w_nxt       = RAW;
      w_stall_if  = 1'b1;
      w_bubble_ex = 1'b1;
      w_new       = '0;
    end
  end

  // Reset masks the combinational decision so nothing leaks out while the
  // scoreboard is being cleared.
  assign stall_if     = rst_n & w_stall_if;
  assign flush_id     = rst_n & w_flush_id;
  assign bubble_ex    = rst_n & w_bubble_ex;
  assign freeze       = rst_n & w_freeze;
  assign state        = r_state;
  assign stall_cycles = r_sc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb    <= '0;
      r_state <= RUN;
      r_sc    <= '0;
    end else begin
      // A frozen pipe holds every stage, so the shadow holds too and the
      // pending decision is re-evaluated once memory is ready.
      if (!mem_busy) r_sb <= {r_sb[MEM], r_sb[EX], w_new};
      r_state <= w_nxt;
      if (clr_stats)                        r_sc <= '0;
      else if (w_nxt != RUN && r_sc != '1)  r_sc <= r_sc + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_interlock_ctrl.sv
module tb_pipe_interlock_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0, id_wr = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic ex_redirect = 0, mem_busy = 0, clr_stats = 0;
  logic stall_if, flush_id, bubble_ex, freeze;
  logic [1:0] state;
  logic [15:0] stall_cycles;
  logic s4_if, s4_fid, s4_bex, s4_frz;
  logic [1:0] s4_state;
  logic [3:0] s4_sc;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_interlock_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wr(id_wr),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .clr_stats(clr_stats),
    .stall_if(stall_if), .flush_id(flush_id), .bubble_ex(bubble_ex), .freeze(freeze),
    .state(state), .stall_cycles(stall_cycles));

  pipe_interlock_ctrl #(.STATW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wr(id_wr),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .clr_stats(clr_stats),
    .stall_if(s4_if), .flush_id(s4_fid), .bubble_ex(s4_bex), .freeze(s4_frz),
    .state(s4_state), .stall_cycles(s4_sc));

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       wr, rdr, bsy, clr;
    logic [3:0] ctl;   // {stall_if, flush_id, bubble_ex, freeze}
    logic [1:0] st;    // state before this edge
    logic [15:0] sc;   // stall_cycles before this edge
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(int v, int rs1, int rs2, int u1, int u2, int rd, int wr,
                              int rdr, int bsy, int clr, int ctl, int st, int sc);
    vec_t r;
    r.v = 1'(v); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = 1'(u1); r.u2 = 1'(u2);
    r.rd = 5'(rd); r.wr = 1'(wr); r.rdr = 1'(rdr); r.bsy = 1'(bsy); r.clr = 1'(clr);
    r.ctl = 4'(ctl); r.st = 2'(st); r.sc = 16'(sc);
    return r;
  endfunction

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2; id_use_rs1 = t.u1; id_use_rs2 = t.u2;
    id_rd = t.rd; id_wr = t.wr; ex_redirect = t.rdr; mem_busy = t.bsy; clr_stats = t.clr;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(mk(1, 5, 5, 1, 1, 5, 1, 1, 1, 0, 0, 0, 0));
    #1;
    chk("reset_ctl", {28'd0, stall_if, flush_id, bubble_ex, freeze}, 32'd0);
    chk("reset_state_sc", {14'd0, state, stall_cycles}, 32'd0);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
  endtask

  initial begin
    // Back-to-back RAW on EX producer: 2 stalls, then issue.
    tv.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 4'b0000, 0, 0));
    tv.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 4'b1010, 0, 0));
    tv.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 4'b1010, 1, 1));
    tv.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 4'b0000, 1, 2));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 2));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 2));
    // x0 producer never stalls.
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0));
    tv.push_back(mk(1, 0, 0, 1, 0, 7, 0, 0, 0, 0, 4'b0000, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
    // Invalid decode ignored; MEM producer resolves in 1 stall; WB never stalls.
    tv.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 4'b0000, 0, 0));
    tv.push_back(mk(0, 9, 0, 1, 0, 9, 1, 0, 0, 0, 4'b0000, 0, 0));
    tv.push_back(mk(1, 0, 9, 0, 1, 10, 0, 0, 0, 0, 4'b1010, 0, 0));
    tv.push_back(mk(1, 0, 9, 0, 1, 10, 0, 0, 0, 0, 4'b0000, 1, 1));
    // Unused sources do not stall.
    tv.push_back(mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 4'b0000, 0, 1));
    tv.push_back(mk(1, 11, 11, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1));
    // Redirect wins over RAW in the same cycle.
    tv.push_back(mk(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 4'b0000, 0, 1));
    tv.push_back(mk(1, 12, 0, 1, 0, 0, 0, 1, 0, 0, 4'b0110, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3, 2));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 2));
    // mem_busy x3 during RAW on MEM producer (plus redirect, lower priority).
    tv.push_back(mk(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 4'b0000, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
    tv.push_back(mk(1, 13, 0, 1, 0, 14, 0, 0, 1, 0, 4'b1001, 0, 0));
    tv.push_back(mk(1, 13, 0, 1, 0, 14, 0, 1, 1, 0, 4'b1001, 2, 1));
    tv.push_back(mk(1, 13, 0, 1, 0, 14, 0, 0, 1, 0, 4'b1001, 2, 2));
    tv.push_back(mk(1, 13, 0, 1, 0, 14, 0, 0, 0, 0, 4'b1010, 2, 3));
    tv.push_back(mk(1, 13, 0, 1, 0, 14, 0, 0, 0, 0, 4'b0000, 1, 4));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 4));

    do_reset();
    foreach (tv[i]) begin
      drive(tv[i]);
      #1;
      n_vec++;
      if ({stall_if, flush_id, bubble_ex, freeze} !== tv[i].ctl ||
          state !== tv[i].st || stall_cycles !== tv[i].sc) begin
        n_bad++;
        $display("FAIL vec%0d: ctl=%b st=%0d sc=%0d expected ctl=%b st=%0d sc=%0d", i,
                 {stall_if, flush_id, bubble_ex, freeze}, state, stall_cycles,
                 tv[i].ctl, tv[i].st, tv[i].sc);
      end
      @(negedge clk);
    end

    // Saturation on the 4-bit counter; clear wins over a stall.
    do_reset();
    mem_busy = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("sat4_sc", {28'd0, s4_sc}, 32'd15);
    chk("sat16_sc", {16'd0, stall_cycles}, 32'd20);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    mem_busy = 1'b0;
    #1;
    chk("clr_wins_sc", {28'd0, s4_sc}, 32'd0);
    chk("clr_wins_state", {30'd0, s4_state}, 32'd2);

    // Reset pulse in the middle of a RAW stall.
    do_reset();
    drive(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0, 0));
    #1;
    chk("pre_rst_ctl", {28'd0, stall_if, flush_id, bubble_ex, freeze}, 32'b1010);
    @(negedge clk);
    #1;
    chk("pre_rst_state", {30'd0, state}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("in_rst_ctl", {28'd0, stall_if, flush_id, bubble_ex, freeze}, 32'd0);
    chk("in_rst_state_sc", {14'd0, state, stall_cycles}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ctl", {28'd0, stall_if, flush_id, bubble_ex, freeze}, 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst_state_sc", {14'd0, state, stall_cycles}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
